// File: rtl/opq_read_sequencer.sv
// Round-robin front end for one lane operand queue: accepts an operand-fetch
// request, pushes its conversion command, then streams VRF word reads into the queue.
module opq_read_sequencer #(
  parameter int unsigned NrRequesters = 2,
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned VlWidth      = 16,
  parameter int unsigned CmdDepth     = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrRequesters-1:0]           req_valid_i,
  output logic [NrRequesters-1:0]           req_ready_o,
  input  logic [NrRequesters*AddrWidth-1:0] req_addr_i,
  input  logic [NrRequesters*VlWidth-1:0]   req_vl_i,
  input  logic [NrRequesters*2-1:0]         req_eew_i,
  input  logic [NrRequesters*4-1:0]         req_conv_i,
  input  logic [NrRequesters-1:0]           req_target_fu_i,
  output logic                              opq_cmd_valid_o,
  output logic [VlWidth-1:0]                opq_cmd_vl_o,
  output logic [1:0]                        opq_cmd_eew_o,
  output logic [3:0]                        opq_cmd_conv_o,
  output logic                              opq_cmd_target_fu_o,
  input  logic                              opq_cmd_pop_i,
  input  logic                              opq_ready_i,
  output logic                              vrf_req_o,
  output logic [AddrWidth-1:0]              vrf_addr_o,
  input  logic                              vrf_gnt_i,
  output logic                              opq_issued_o,
  output logic                              busy_o
);

  localparam int unsigned RrWidth     = (NrRequesters > 1) ? $clog2(NrRequesters) : 1;
  localparam int unsigned CntWidth    = $clog2(CmdDepth + 1);
  localparam int unsigned WordsWidth  = VlWidth + 1;
  localparam int unsigned ScaledWidth = VlWidth + 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [RrWidth-1:0]    rr_q, rr_d;
  logic [CntWidth-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [WordsWidth-1:0] words_q, words_d;

  logic                   win_found;
  logic [RrWidth-1:0]     win_idx;
  logic [RrWidth:0]       cand;
  logic [RrWidth:0]       rr_inc;
  logic [AddrWidth-1:0]   win_addr;
  logic [VlWidth-1:0]     win_vl;
  logic [1:0]             win_eew;
  logic [3:0]             win_conv;
  logic                   win_fu;
  logic [ScaledWidth-1:0] scaled;
  logic [WordsWidth-1:0]  win_words;
  logic                   pop_ok;

  // Round-robin search upward from rr_q, wrapping modulo NrRequesters.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NrRequesters; i++) begin
      cand = {1'b0, rr_q} + (RrWidth+1)'(i);
      if (cand >= (RrWidth+1)'(NrRequesters)) begin
        cand = cand - (RrWidth+1)'(NrRequesters);
      end
      if (!win_found && req_valid_i[RrWidth'(cand)]) begin
        win_found = 1'b1;
        win_idx   = RrWidth'(cand);
      end
    end
  end

  assign win_addr  = req_addr_i[win_idx*AddrWidth +: AddrWidth];
  assign win_vl    = req_vl_i[win_idx*VlWidth +: VlWidth];
  assign win_eew   = req_eew_i[win_idx*2 +: 2];
  assign win_conv  = req_conv_i[win_idx*4 +: 4];
  assign win_fu    = req_target_fu_i[win_idx];
  assign rr_inc    = {1'b0, win_idx} + (RrWidth+1)'(1);
  // Bytes of source data rounded up to 64-bit VRF words.
  assign scaled    = ScaledWidth'(win_vl) << win_eew;
  assign win_words = WordsWidth'((scaled + ScaledWidth'(7)) >> 3);

  // Next-state and outputs.
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    addr_d          = addr_q;
    words_d         = words_q;
    cmd_cnt_d       = cmd_cnt_q;
    req_ready_o     = '0;
    opq_cmd_valid_o = 1'b0;
    vrf_req_o       = 1'b0;
    pop_ok          = opq_cmd_pop_i && (cmd_cnt_q != '0);

    case (state_q)
      IDLE: begin
        if (win_found && (cmd_cnt_q < CntWidth'(CmdDepth))) begin
          req_ready_o[win_idx] = 1'b1;
          rr_d    = (rr_inc >= (RrWidth+1)'(NrRequesters)) ? '0 : RrWidth'(rr_inc);
          addr_d  = win_addr;
          words_d = win_words;
          if (win_vl != '0) begin
            opq_cmd_valid_o = 1'b1;
            state_d         = BUSY;
          end
        end
      end
      BUSY: begin
        vrf_req_o = opq_ready_i;
        if (opq_ready_i && vrf_gnt_i) begin
          addr_d  = addr_q + AddrWidth'(1);
          words_d = words_q - WordsWidth'(1);
          if (words_q == WordsWidth'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (opq_cmd_valid_o && !pop_ok) begin
      cmd_cnt_d = cmd_cnt_q + CntWidth'(1);
    end else if (!opq_cmd_valid_o && pop_ok) begin
      cmd_cnt_d = cmd_cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cmd_cnt_q <= '0;
      addr_q    <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cmd_cnt_q <= cmd_cnt_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
    end
  end

  assign opq_cmd_vl_o        = opq_cmd_valid_o ? win_vl : '0;
  assign opq_cmd_eew_o       = opq_cmd_valid_o ? win_eew : '0;
  assign opq_cmd_conv_o      = opq_cmd_valid_o ? win_conv : '0;
  assign opq_cmd_target_fu_o = opq_cmd_valid_o & win_fu;
  assign vrf_addr_o          = addr_q;
  assign opq_issued_o        = vrf_req_o & vrf_gnt_i;
  assign busy_o              = (state_q == BUSY);

  // A pop with no outstanding command means the queue and this block disagree.
  pop_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    opq_cmd_pop_i |-> (cmd_cnt_q != '0));

endmodule

// File: tb/tb_opq_read_sequencer.sv
// Scoreboard bench for opq_read_sequencer: stimulus queues expected accepts,
// commands and read addresses; a negedge monitor pops and compares them.
module tb_opq_read_sequencer;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned VW = 16;
  localparam int unsigned CD = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   r_addr [N];
  logic [VW-1:0]   r_vl   [N];
  logic [1:0]      r_eew  [N];
  logic [3:0]      r_conv [N];
  logic [N-1:0]    r_fu;
  logic [N*AW-1:0] req_addr;
  logic [N*VW-1:0] req_vl;
  logic [N*2-1:0]  req_eew;
  logic [N*4-1:0]  req_conv;
  logic            cmd_valid, cmd_fu, cmd_pop, opq_ready, vrf_req, vrf_gnt, issued, busy;
  logic [VW-1:0]   cmd_vl;
  logic [1:0]      cmd_eew;
  logic [3:0]      cmd_conv;
  logic [AW-1:0]   vrf_addr;

  assign req_addr = {r_addr[1], r_addr[0]};
  assign req_vl   = {r_vl[1], r_vl[0]};
  assign req_eew  = {r_eew[1], r_eew[0]};
  assign req_conv = {r_conv[1], r_conv[0]};

  opq_read_sequencer #(
    .NrRequesters(N), .AddrWidth(AW), .VlWidth(VW), .CmdDepth(CD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_vl_i(req_vl), .req_eew_i(req_eew),
    .req_conv_i(req_conv), .req_target_fu_i(r_fu),
    .opq_cmd_valid_o(cmd_valid), .opq_cmd_vl_o(cmd_vl), .opq_cmd_eew_o(cmd_eew),
    .opq_cmd_conv_o(cmd_conv), .opq_cmd_target_fu_o(cmd_fu),
    .opq_cmd_pop_i(cmd_pop), .opq_ready_i(opq_ready),
    .vrf_req_o(vrf_req), .vrf_addr_o(vrf_addr), .vrf_gnt_i(vrf_gnt),
    .opq_issued_o(issued), .busy_o(busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pending = 0;
  int pop_budget = 0;
  int busy_cnt = 0;
  int nogrant_cnt = 0;
  int pop_cyc = 0;
  logic [N-1:0]  exp_acc [$];
  logic [22:0]   exp_cmd [$];
  logic [AW-1:0] exp_iss [$];
  int acc_cyc [$];
  int iss_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Command-queue model: pops only while commands are outstanding and budget remains.
  always @(posedge clk) begin
    #1;
    if (pop_budget > 0 && pending > 0) begin
      cmd_pop = 1'b1;
      pop_budget--;
    end else begin
      cmd_pop = 1'b0;
    end
  end

  // Monitor: compare every observed accept, command push and issued read.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (req_ready != '0) begin
        acc_cyc.push_back(cyc);
        if (exp_acc.size() == 0) unexp("accept", 32'(req_ready));
        else chk("accept", 32'(req_ready), 32'(exp_acc.pop_front()));
      end
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) unexp("cmd", 32'({cmd_vl, cmd_eew, cmd_conv, cmd_fu}));
        else chk("cmd", 32'({cmd_vl, cmd_eew, cmd_conv, cmd_fu}), 32'(exp_cmd.pop_front()));
      end
      if (vrf_req || issued) chk("issued_eq", 32'(issued), 32'(vrf_req & vrf_gnt));
      if (vrf_req && !vrf_gnt) nogrant_cnt++;
      if (issued) begin
        iss_cyc.push_back(cyc);
        if (exp_iss.size() == 0) unexp("read_addr", 32'(vrf_addr));
        else chk("read_addr", 32'(vrf_addr), 32'(exp_iss.pop_front()));
      end
      if (busy) busy_cnt++;
      if (cmd_pop) begin
        pop_cyc = cyc;
        if (pending > 0) pending--;
      end
      if (cmd_valid) pending++;
    end
  end

  task automatic check_quiet(input string name);
    chk({name, "_ctl"}, 32'({req_ready, cmd_valid, vrf_req, issued, busy}), 32'd0);
    chk({name, "_data"}, 32'({cmd_vl, cmd_eew, cmd_conv, cmd_fu, vrf_addr}), 32'd0);
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    req_valid  = '0;
    opq_ready  = 1'b1;
    vrf_gnt    = 1'b1;
    pending    = 0;
    pop_budget = 0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("rst");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    iss_cyc.delete();
    busy_cnt    = 0;
    nogrant_cnt = 0;
  endtask

  task automatic load_req(input int r, input logic [AW-1:0] a, input logic [VW-1:0] vl,
                          input logic [1:0] e, input logic [3:0] c, input logic fu,
                          input int nwords);
    exp_acc.push_back(N'(1) << r);
    if (vl != '0) exp_cmd.push_back({vl, e, c, fu});
    for (int k = 0; k < nwords; k++) exp_iss.push_back(a + AW'(k));
    r_addr[r] = a;
    r_vl[r]   = vl;
    r_eew[r]  = e;
    r_conv[r] = c;
    r_fu[r]   = fu;
  endtask

  task automatic wait_acc(input int r);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready[r]) break;
      t++;
      if (t >= 50) begin
        unexp("accept_timeout", 32'(r));
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic [AW-1:0] a, input logic [VW-1:0] vl,
                       input logic [1:0] e, input logic [3:0] c, input logic fu,
                       input int nwords);
    load_req(r, a, vl, e, c, fu, nwords);
    req_valid[r] = 1'b1;
    wait_acc(r);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) unexp("idle_timeout", 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] rdy_pat;
    logic [8:0] gnt_pat;
    int cnt;
    int t;
    rdy_pat = 9'b101010101;
    gnt_pat = 9'b111111011;
    for (int i = 0; i < int'(N); i++) begin
      r_addr[i] = '0; r_vl[i] = '0; r_eew[i] = '0; r_conv[i] = '0;
    end
    r_fu = '0; req_valid = '0; opq_ready = 1'b1; vrf_gnt = 1'b1; cmd_pop = 1'b0;

    // Single 3-word transfer wrapping the address space.
    do_reset(); clear_logs(); pop_budget = 1000;
    issue(0, 10'h3FE, 16'd10, 2'd1, 4'h5, 1'b1, 3);
    wait_idle();
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("t1_reads", 32'(iss_cyc.size()), 32'd3);
    if (iss_cyc.size() == 3 && acc_cyc.size() == 1) begin
      chk("t1_first_latency", 32'(iss_cyc[0] - acc_cyc[0]), 32'd1);
      chk("t1_back_to_back", 32'(iss_cyc[2] - iss_cyc[0]), 32'd2);
    end

    // Round-robin with both requesters continuously valid.
    do_reset(); clear_logs(); pop_budget = 1000;
    load_req(0, 10'h010, 16'd8, 2'd0, 4'h1, 1'b0, 1);
    load_req(1, 10'h020, 16'd8, 2'd0, 4'h2, 1'b1, 1);
    load_req(0, 10'h010, 16'd8, 2'd0, 4'h1, 1'b0, 1);
    load_req(1, 10'h020, 16'd8, 2'd0, 4'h2, 1'b1, 1);
    req_valid = 2'b11;
    cnt = 0; t = 0;
    while (cnt < 4 && t < 60) begin
      @(negedge clk);
      if (req_ready != '0) cnt++;
      t++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("t2_accepts", 32'(acc_cyc.size()), 32'd4);
    chk("t2_reads", 32'(iss_cyc.size()), 32'd4);
    if (iss_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("t2_read_gap", 32'(iss_cyc[k] - iss_cyc[k-1]), 32'd2);
    end

    // Credit stall: two commands fill the buffer, third waits for a pop.
    do_reset(); clear_logs(); pop_budget = 0;
    issue(0, 10'h100, 16'd1, 2'd0, 4'h0, 1'b0, 1);
    issue(0, 10'h200, 16'd1, 2'd0, 4'h3, 1'b0, 1);
    load_req(0, 10'h300, 16'd1, 2'd0, 4'h9, 1'b1, 1);
    req_valid[0] = 1'b1;
    fork
      wait_acc(0);
      begin
        repeat (6) @(negedge clk);
        chk("t3_stalled", 32'(acc_cyc.size()), 32'd2);
        pop_budget = 1;
      end
    join
    wait_idle();
    if (acc_cyc.size() == 3) begin
      chk("t3_no_stall_first_two", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("t3_accept_after_pop", 32'(acc_cyc[2] - pop_cyc), 32'd1);
    end else begin
      unexp("t3_accepts", 32'(acc_cyc.size()));
    end

    // Backpressure: ready toggles, one withheld grant.
    do_reset(); clear_logs(); pop_budget = 1000;
    issue(1, 10'h050, 16'd4, 2'd3, 4'hA, 1'b0, 4);
    for (int k = 0; k < 9; k++) begin
      opq_ready = rdy_pat[k];
      vrf_gnt   = gnt_pat[k];
      @(posedge clk); #1;
    end
    opq_ready = 1'b1; vrf_gnt = 1'b1;
    wait_idle();
    chk("t4_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t4_reads", 32'(iss_cyc.size()), 32'd4);
    chk("t4_ungranted", 32'(nogrant_cnt), 32'd1);
    if (iss_cyc.size() == 4) chk("t4_stall_span", 32'(iss_cyc[1] - iss_cyc[0]), 32'd4);

    // vl=0 is acknowledged without command or reads, then a 2-word transfer.
    do_reset(); clear_logs(); pop_budget = 1000;
    issue(0, 10'h0C0, 16'd0, 2'd2, 4'h1, 1'b0, 0);
    issue(1, 10'h0A0, 16'd3, 2'd2, 4'h6, 1'b1, 2);
    wait_idle();
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("t5_reads", 32'(iss_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("t5_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);

    // Reset after the first of three words aborts the transfer.
    do_reset(); clear_logs(); pop_budget = 0;
    load_req(0, 10'h1F0, 16'd3, 2'd3, 4'h0, 1'b0, 1);
    req_valid[0] = 1'b1;
    wait_acc(0);
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    pending = 0;
    #1;
    check_quiet("t6_abort");
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    issue(0, 10'h222, 16'd8, 2'd0, 4'h0, 1'b0, 1);
    issue(1, 10'h333, 16'd8, 2'd0, 4'h7, 1'b1, 1);
    wait_idle();
    chk("t6_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("t6_no_credit_stall", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);

    repeat (3) @(posedge clk);
    chk("left_accepts", 32'(exp_acc.size()), 32'd0);
    chk("left_cmds", 32'(exp_cmd.size()), 32'd0);
    chk("left_reads", 32'(exp_iss.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
